// File: rtl/fpu_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_xfer_seq
//  Description : Sequences FP-register <-> memory operand transfers
//                (LDF/STF class). A store splits a 32/64-bit FP register
//                into 2/4 big-endian 16-bit bus words. A load assembles
//                2/4 bus words into a single register-file write.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TMO_CYC   bus-ack timeout in clocks (FPU_XFER_TIMEOUT_EN builds only)
//  Optional feature macro
//    FPU_XFER_TIMEOUT_EN  abort a word that waits TMO_CYC clocks for mack
//  Ports
//    clk, rst          clock / asynchronous active-high reset
//    start_i           transfer request, honoured in IDLE only
//    dir_i             0 = load (mem->reg), 1 = store (reg->mem)
//    regsel_i          FP register 0..5 (6/7 rejected with err_o)
//    fpmode_i          0 = 2 words, 1 = 4 words
//    base_i            byte address of the first word
//    busy_o/done_o/err_o   status, done/err are one-clock pulses
//    raddr_o, rdat_i   register-file read port
//    waddr_o, wdat_o, rf_mode_o, we_o   register-file write port
//    mreq_o, mwe_o, maddr_o, mdout_o, mdin_i, mack_i   word bus
// ============================================================================
module fpu_xfer_seq #(
  parameter int TMO_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        dir_i,
  input  logic [2:0]  regsel_i,
  input  logic        fpmode_i,
  input  logic [15:0] base_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  raddr_o,
  input  logic [63:0] rdat_i,
  output logic [2:0]  waddr_o,
  output logic [63:0] wdat_o,
  output logic        rf_mode_o,
  output logic        we_o,
  output logic        mreq_o,
  output logic        mwe_o,
  output logic [15:0] maddr_o,
  output logic [15:0] mdout_o,
  input  logic [15:0] mdin_i,
  input  logic        mack_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS   = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_WRREG = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q,   idx_d;
  logic        dir_q,   dir_d;
  logic [2:0]  reg_q,   reg_d;
  logic        mode_q,  mode_d;
  logic [15:0] maddr_q, maddr_d;
  logic [63:0] buf_q,   buf_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;
  logic        w_last;

`ifdef FPU_XFER_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Word index of the final word: 1 for 32-bit operands, 3 for 64-bit.
  assign w_last = (idx_q == (mode_q ? 2'd3 : 2'd1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    reg_d   = reg_q;
    mode_d  = mode_q;
    maddr_d = maddr_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef FPU_XFER_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (regsel_i >= 3'd6) begin
            err_d = 1'b1;
          end else begin
            state_d = S_BUS;
            idx_d   = 2'd0;
            dir_d   = dir_i;
            reg_d   = regsel_i;
            mode_d  = fpmode_i;
            maddr_d = base_i;
            // Store snapshots the register once; the bus then drains
            // the top 16 bits of this buffer word by word.
            buf_d   = dir_i ? rdat_i : 64'h0;
`ifdef FPU_XFER_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      S_BUS: begin
        if (mack_i) begin
          buf_d = dir_q ? {buf_q[47:0], 16'h0000} : {buf_q[47:0], mdin_i};
          if (w_last) begin
            if (dir_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_WRREG;
            end
          end else begin
            idx_d   = idx_q + 2'd1;
            maddr_d = maddr_q + 16'd2;
            state_d = S_GAP;
          end
        end
`ifdef FPU_XFER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        state_d = S_BUS;
`ifdef FPU_XFER_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WRREG: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      dir_q   <= 1'b0;
      reg_q   <= 3'd0;
      mode_q  <= 1'b0;
      maddr_q <= 16'h0000;
      buf_q   <= 64'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef FPU_XFER_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      reg_q   <= reg_d;
      mode_q  <= mode_d;
      maddr_q <= maddr_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef FPU_XFER_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign mreq_o    = (state_q == S_BUS);
  assign mwe_o     = (state_q == S_BUS) && dir_q;
  assign we_o      = (state_q == S_WRREG);
  // Register-file controls follow the request inputs while idle so the
  // store snapshot on the start edge reads the requested register.
  assign raddr_o   = busy_o ? reg_q  : regsel_i;
  assign waddr_o   = busy_o ? reg_q  : regsel_i;
  assign rf_mode_o = busy_o ? mode_q : fpmode_i;
  assign maddr_o   = maddr_q;
  assign mdout_o   = buf_q[63:48];
  // A 32-bit load leaves its two words in buffer[31:0]; they form the
  // high half of the register image.
  assign wdat_o    = mode_q ? buf_q : {buf_q[31:0], 32'h0000_0000};

endmodule
`default_nettype wire

// File: tb/tb_fpu_xfer_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fpu_xfer_seq
//  Description : Self-checking bench for fpu_xfer_seq with a transaction-level
//                reference model (expected words, addresses, latency and
//                register image derived from the operand, not the FSM).
//  Revision    : 1.0  initial release
//  Macro       : FPU_XFER_TIMEOUT_EN selects the expected timeout behaviour.
// ============================================================================
module tb_fpu_xfer_seq;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, dir, fpmode, mack;
  logic [2:0]  regsel;
  logic [15:0] base, mdin;
  logic        busy, done, err, rf_mode, we, mreq, mwe;
  logic [2:0]  raddr, waddr;
  logic [63:0] rdat, wdat;
  logic [15:0] maddr, mdout;

  logic [63:0] rf [0:7];
  int          dly [0:3];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign rdat = rf[raddr];

  fpu_xfer_seq #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start), .dir_i(dir), .regsel_i(regsel),
    .fpmode_i(fpmode), .base_i(base), .busy_o(busy), .done_o(done),
    .err_o(err), .raddr_o(raddr), .rdat_i(rdat), .waddr_o(waddr),
    .wdat_o(wdat), .rf_mode_o(rf_mode), .we_o(we), .mreq_o(mreq),
    .mwe_o(mwe), .maddr_o(maddr), .mdout_o(mdout), .mdin_i(mdin),
    .mack_i(mack)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // One transfer against the model. rst_word >= 0 asserts rst mid-cycle
  // on the first clock of that word and abandons the transfer.
  task automatic run_xfer(input bit d, input logic [2:0] r, input bit m,
                          input logic [15:0] b, input int rst_word,
                          input bit noise);
    int n, exp_lat, k, w, wait_c, we_seen;
    logic [15:0] words [0:3];
    logic [63:0] img, exp_wdat;
    logic [15:0] hold_a, hold_d, ea;
    bit in_req, fin;
    n   = m ? 4 : 2;
    img = rf[r];
    for (int i = 0; i < 4; i++)
      words[i] = d ? img[63-16*i -: 16] : 16'($urandom);
    exp_wdat = m ? {words[0], words[1], words[2], words[3]}
                 : {words[0], words[1], 32'h0};
    exp_lat = (n - 1) + (d ? 0 : 1);
    for (int i = 0; i < n; i++) exp_lat += 1 + dly[i];

    start = 1'b1; dir = d; regsel = r; fpmode = m; base = b; mack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; w = 0; wait_c = 0; we_seen = 0; in_req = 0; fin = 0;
    hold_a = '0; hold_d = '0;
    while (!fin) begin
      if (done) begin
        n_tests++;
        if (k !== exp_lat) begin
          n_fail++; $display("FAIL latency: got %0d expected %0d", k, exp_lat);
        end
        n_tests++;
        if (we_seen !== (d ? 0 : 1) || w !== n) begin
          n_fail++;
          $display("FAIL counts: we %0d words %0d expected we %0d words %0d",
                   we_seen, w, d ? 0 : 1, n);
        end
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL busy_at_done: got %b expected 0", busy);
        end
        fin = 1;
      end else if (err || k > exp_lat + 4 || w >= n && mreq) begin
        n_tests++; n_fail++;
        $display("FAIL transfer: err %b clock %0d words %0d mreq %b (expected done at %0d)",
                 err, k, w, mreq, exp_lat);
        fin = 1;
      end else begin
        n_tests++;
        if (busy !== 1'b1 || raddr !== r || waddr !== r || rf_mode !== m) begin
          n_fail++;
          $display("FAIL latch: busy %b raddr %0d waddr %0d mode %b expected 1 %0d %0d %b",
                   busy, raddr, waddr, rf_mode, r, r, m);
        end
        if (we) begin
          we_seen++;
          n_tests++;
          if (waddr !== r || wdat !== exp_wdat || w !== n) begin
            n_fail++;
            $display("FAIL regwrite: waddr %0d wdat %h expected %0d %h", waddr, wdat, r, exp_wdat);
          end
        end
        if (mreq) begin
          if (!in_req) begin
            in_req = 1; wait_c = 0; hold_a = maddr; hold_d = mdout;
            ea = b + 16'(2 * w);
            n_tests++;
            if (maddr !== ea || mwe !== d || (d && mdout !== words[w])) begin
              n_fail++;
              $display("FAIL word%0d: addr %h data %h mwe %b expected %h %h %b",
                       w, maddr, mdout, mwe, ea, words[w], d);
            end
          end else begin
            n_tests++;
            if (maddr !== hold_a || mdout !== hold_d) begin
              n_fail++;
              $display("FAIL hold: addr %h data %h expected %h %h", maddr, mdout, hold_a, hold_d);
            end
          end
          if (rst_word == w) begin
            mack = 1'b0;
            #2 rst = 1'b1;
            #1;
            n_tests++;
            if ({busy, done, err, we, mreq, mwe} !== 6'b0 || maddr !== 16'h0 ||
                mdout !== 16'h0 || wdat !== 64'h0 || we_seen !== 0) begin
              n_fail++;
              $display("FAIL async_reset: busy %b done %b err %b we %b mreq %b maddr %h wdat %h we_seen %0d expected all 0",
                       busy, done, err, we, mreq, maddr, wdat, we_seen);
            end
            @(posedge clk); #1;
            rst = 1'b0;
            return;
          end
          mack = (wait_c >= dly[w]);
          mdin = mack ? words[w] : 16'($urandom);
          if (mack) begin w++; in_req = 0; end
          wait_c++;
        end else begin
          mack = noise ? 1'($urandom) : 1'b0;
          mdin = 16'($urandom);
        end
        if (noise) begin
          start = 1'($urandom); dir = 1'($urandom);
          regsel = 3'($urandom); fpmode = 1'($urandom); base = 16'($urandom);
        end
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0; mack = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse: done %b err %b busy %b expected 0 0 0", done, err, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dir = 1'b0; fpmode = 1'b1; regsel = 3'd3;
    base = 16'h1234; mack = 1'b0; mdin = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, err, we, mreq, mwe} !== 6'b0 || maddr !== 16'h0 ||
        mdout !== 16'h0 || wdat !== 64'h0) begin
      n_fail++;
      $display("FAIL reset: busy %b done %b err %b we %b mreq %b mwe %b maddr %h mdout %h wdat %h expected 0",
               busy, done, err, we, mreq, mwe, maddr, mdout, wdat);
    end
    n_tests++;
    if (raddr !== 3'd3 || waddr !== 3'd3 || rf_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_pass: raddr %0d waddr %0d mode %b expected 3 3 1", raddr, waddr, rf_mode);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store64;
    rf[2] = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 4; i++) dly[i] = 0;
    run_xfer(1'b1, 3'd2, 1'b1, 16'o1000, -1, 1'b0);
  endtask

  task automatic test_load32;
    for (int i = 0; i < 4; i++) dly[i] = 0;
    run_xfer(1'b0, 3'd5, 1'b0, 16'o2000, -1, 1'b0);
  endtask

  task automatic test_illegal_reg;
    for (int v = 6; v < 8; v++) begin
      start = 1'b1; dir = 1'($urandom); regsel = 3'(v); fpmode = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (err !== 1'b1 || busy !== 1'b0 || mreq !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_reg%0d: err %b busy %b mreq %b expected 1 0 0", v, err, busy, mreq);
      end
      for (int c = 0; c < 4; c++) begin
        mack = 1'($urandom);
        @(posedge clk); #1;
        n_tests++;
        if (err !== 1'b0 || mreq !== 1'b0 || we !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL illegal_after: err %b mreq %b we %b busy %b expected 0", err, mreq, we, busy);
        end
      end
      mack = 1'b0;
    end
  endtask

  task automatic test_delayed_ack;
    rf[1] = {$urandom, $urandom};
    dly[0] = 0; dly[1] = 5; dly[2] = 0; dly[3] = 0;
    run_xfer(1'b1, 3'd1, 1'b1, 16'hFFFC, -1, 1'b0);
    run_xfer(1'b0, 3'd4, 1'b1, 16'h0100, -1, 1'b1);
  endtask

  task automatic test_random;
    for (int t = 0; t < 24; t++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 5));
      rf[r] = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) dly[i] = $urandom_range(0, 3);
      run_xfer(1'($urandom), r, 1'($urandom),
               (t % 6 == 0) ? 16'hFFFE : 16'($urandom), -1, 1'b1);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) dly[i] = 1;
    run_xfer(1'b0, 3'd3, 1'b1, 16'h4000, 2, 1'b0);
    rf[0] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) dly[i] = 0;
    run_xfer(1'b1, 3'd0, 1'b0, 16'h0040, -1, 1'b0);
    run_xfer(1'b0, 3'd3, 1'b1, 16'h4000, -1, 1'b0);
  endtask

  task automatic test_timeout;
    int first_err;
    bit saw_bad;
    start = 1'b1; dir = 1'b0; regsel = 3'd1; fpmode = 1'b1; base = 16'h0800;
    mack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    first_err = -1; saw_bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (err && first_err < 0) first_err = k;
      if (we || done) saw_bad = 1;
      if (k == 19) break;
      @(posedge clk); #1;
    end
    n_tests++;
    if (saw_bad) begin
      n_fail++; $display("FAIL timeout_side: we or done asserted, expected neither");
    end
`ifdef FPU_XFER_TIMEOUT_EN
    n_tests++;
    if (first_err !== TMO || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: err at clock %0d busy %b expected %0d 0", first_err, busy, TMO);
    end
`else
    n_tests++;
    if (first_err !== -1 || busy !== 1'b1 || mreq !== 1'b1) begin
      n_fail++;
      $display("FAIL no_timeout: err at %0d busy %b mreq %b expected -1 1 1", first_err, busy, mreq);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) dly[i] = 0;
    test_reset;
    test_store64;
    test_load32;
    test_illegal_reg;
    test_delayed_ack;
    test_random;
    test_reset_mid;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
